// File: rtl/ch_pkg.sv
// Shared definitions for the capture controller: geometry defaults,
// read-latency range and the FSM state encoding.
package ch_pkg;

    localparam int CH_AW         = 11;
    localparam int CH_DW         = 32;
    localparam int CH_RD_LAT_MIN = 1;
    localparam int CH_RD_LAT_MAX = 2;
    localparam int CH_RD_LAT_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRE       = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4,
        ST_READ      = 3'd5
    } ch_state_t;

    // Bound a requested read latency to what the buffer memory supports.
    function automatic int ch_rd_lat_clamp(input int lat);
        if (lat < CH_RD_LAT_MIN) return CH_RD_LAT_MIN;
        if (lat > CH_RD_LAT_MAX) return CH_RD_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/ch_capture_ctrl_if.sv
// Buffer-memory port bundle between the capture controller and ch_mem_buf.
// Write side is a plain strobe (mem_wren) with no back-pressure; read side
// returns mem_q a fixed number of cycles after mem_rdaddress is presented.
interface ch_capture_ctrl_if #(
    parameter int AW = ch_pkg::CH_AW,
    parameter int DW = ch_pkg::CH_DW
);
    logic [AW-1:0] mem_wraddress;
    logic [DW-1:0] mem_data;
    logic          mem_wren;
    logic [AW-1:0] mem_rdaddress;
    logic [DW-1:0] mem_q;

    modport master (
        output mem_wraddress, mem_data, mem_wren, mem_rdaddress,
        input  mem_q
    );

    modport slave (
        input  mem_wraddress, mem_data, mem_wren, mem_rdaddress,
        output mem_q
    );
endinterface

// File: rtl/ch_rd_pipe.sv
// Valid delay line matching the buffer read latency; flush clears every
// in-flight valid so an aborted readout produces no further words.
module ch_rd_pipe #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_issue,
    input  logic i_flush,
    output logic o_valid
);
    logic [LAT-1:0] r_vld;

    // Shift issue strobes through LAT stages; flush empties the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
        end else if (i_flush) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= i_issue;
            for (int i = 1; i < LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    assign o_valid = r_vld[LAT-1];
endmodule

// File: rtl/ch_capture_ctrl.sv
// Pre/post-trigger capture controller for an external circular buffer.
// Samples are written while armed; after the trigger the window
// [trig_addr-pre_len, trig_addr+post_len] is read back in time order.
// s_valid is a strobe with no ready: every strobe in a writing state is
// stored in that same cycle.
module ch_capture_ctrl
    import ch_pkg::*;
#(
    parameter int AW     = CH_AW,
    parameter int DW     = CH_DW,
    parameter int RD_LAT = CH_RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              abort,
    input  logic [AW-1:0]     pre_len,
    input  logic [AW-1:0]     post_len,
    input  logic              s_valid,
    input  logic [DW-1:0]     s_data,
    input  logic              trig,
    input  logic              rd_start,
    ch_capture_ctrl_if.master mem,
    output logic              o_valid,
    output logic [DW-1:0]     o_data,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     trig_addr,
    output ch_state_t         o_dbg_state
);
    localparam int LAT = ch_rd_lat_clamp(RD_LAT);
    localparam int CW  = AW + 1;   // counters must reach 2^AW words

    ch_state_t     r_state;
    ch_state_t     w_nxt_state;
    logic [AW-1:0] r_pre_len;
    logic [AW-1:0] r_post_len;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_trig_addr;
    logic [CW-1:0] r_cnt;

    logic [AW-1:0] w_post_room;
    logic [AW-1:0] w_post_clamped;
    logic [CW-1:0] w_cnt_inc;
    logic [CW-1:0] w_total;
    logic          w_pre_hit;
    logic          w_post_hit;
    logic          w_rd_last;
    logic          w_wren;
    logic          w_issue;
    logic          w_valid;

    // Post length is limited so pre + trigger + post never exceeds the buffer.
    assign w_post_room    = {AW{1'b1}} - pre_len;
    assign w_post_clamped = (post_len > w_post_room) ? w_post_room : post_len;

    assign w_cnt_inc  = r_cnt + CW'(1);
    assign w_total    = {1'b0, r_pre_len} + {1'b0, r_post_len} + CW'(1);
    assign w_pre_hit  = s_valid && (w_cnt_inc == {1'b0, r_pre_len});
    assign w_post_hit = s_valid && (w_cnt_inc == {1'b0, r_post_len});
    assign w_rd_last  = (w_cnt_inc == w_total);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_nxt_state;
    end

    // Next-state logic; abort overrides every other event.
    always_comb begin
        w_nxt_state = r_state;
        if (abort) begin
            w_nxt_state = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE:      if (arm) w_nxt_state = (pre_len == '0) ? ST_WAIT_TRIG : ST_PRE;
                ST_PRE:       if (w_pre_hit) w_nxt_state = ST_WAIT_TRIG;
                ST_WAIT_TRIG: if (s_valid && trig)
                                  w_nxt_state = (r_post_len == '0) ? ST_DONE : ST_POST;
                ST_POST:      if (w_post_hit) w_nxt_state = ST_DONE;
                ST_DONE:      if (rd_start) w_nxt_state = ST_READ;
                ST_READ:      if (w_rd_last) w_nxt_state = ST_IDLE;
                default:      w_nxt_state = ST_IDLE;
            endcase
        end
    end

    // State-decoded outputs: status flags, write strobe and read issue.
    always_comb begin
        busy    = (r_state != ST_IDLE);
        done    = (r_state == ST_DONE);
        w_wren  = 1'b0;
        w_issue = 1'b0;
        if (!abort) begin
            w_wren  = s_valid && ((r_state == ST_PRE) || (r_state == ST_WAIT_TRIG) ||
                                  (r_state == ST_POST));
            w_issue = (r_state == ST_READ);
        end
    end

    // Datapath: lengths, pointers, counter and trigger address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre_len   <= '0;
            r_post_len  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_trig_addr <= '0;
            r_cnt       <= '0;
        end else if (!abort) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (arm) begin
                        r_pre_len  <= pre_len;
                        r_post_len <= w_post_clamped;
                        r_wr_ptr   <= '0;
                        r_cnt      <= '0;
                    end
                end
                ST_PRE: begin
                    if (s_valid) begin
                        r_wr_ptr <= r_wr_ptr + AW'(1);
                        r_cnt    <= w_pre_hit ? '0 : w_cnt_inc;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (s_valid) begin
                        r_wr_ptr <= r_wr_ptr + AW'(1);
                        if (trig) begin
                            r_trig_addr <= r_wr_ptr;
                            r_cnt       <= '0;
                        end
                    end
                end
                ST_POST: begin
                    if (s_valid) begin
                        r_wr_ptr <= r_wr_ptr + AW'(1);
                        r_cnt    <= w_cnt_inc;
                    end
                end
                ST_DONE: begin
                    if (rd_start) begin
                        r_rd_ptr <= r_trig_addr - r_pre_len;
                        r_cnt    <= '0;
                    end
                end
                ST_READ: begin
                    // The final address is kept so the read port holds it idle.
                    r_cnt <= w_cnt_inc;
                    if (!w_rd_last) r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                default: ;
            endcase
        end
    end

    ch_rd_pipe #(.LAT(LAT)) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_issue (w_issue),
        .i_flush (abort),
        .o_valid (w_valid)
    );

    assign mem.mem_wraddress = r_wr_ptr;
    assign mem.mem_data      = s_data;
    assign mem.mem_wren      = w_wren;
    assign mem.mem_rdaddress = r_rd_ptr;

    assign o_valid     = w_valid;
    assign o_data      = w_valid ? mem.mem_q : '0;
    assign trig_addr   = r_trig_addr;
    assign o_dbg_state = r_state;
endmodule
